stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; these are fixed.
REQ-002 Parameter DB_CYCLES, default 100000, SHALL set the consecutive stable cycles needed to accept a button level.
REQ-003 Parameter TICK_DIV, default 1000000, SHALL set the CLK cycles per count tick (100 Hz at 100 MHz).
REQ-004 Port CLK SHALL be an input, 1 bit: system clock.
REQ-005 Port RST SHALL be an input, 1 bit: synchronous active-high reset.
REQ-006 Ports BTNL, BTNR, BTND and BTNU SHALL be inputs, 1 bit each, raw asynchronous buttons: start, stop, clear and lap.
REQ-007 Port cnt_en SHALL be an output, 1 bit: one-cycle increment strobe to the BCD time counter.
REQ-008 Port cnt_clr SHALL be an output, 1 bit: one-cycle clear strobe to the BCD time counter.
REQ-009 Port hold SHALL be an output, 1 bit: freezes the display latch (lap view).
REQ-010 Port state SHALL be an output, 2 bits: current FSM state.
REQ-011 Port running SHALL be an output, 1 bit: high in RUN or LAP.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after DB_CYCLES consecutive equal samples.
REQ-013 Each debouncer SHALL emit a one-cycle press pulse on the cycle its accepted level goes 0->1; a held button SHALL give exactly one pulse, and a release SHALL give none.
REQ-014 FSM encoding SHALL be IDLE=0, RUN=1, STOP=2, LAP=3.
REQ-015 IDLE SHALL go to RUN on start; stop and lap SHALL be ignored; clear SHALL stay in IDLE and pulse cnt_clr.
REQ-016 RUN SHALL go to STOP on stop, to LAP on lap, and to IDLE on clear with a cnt_clr pulse.
REQ-017 LAP SHALL return to RUN on lap, go to STOP on stop, and go to IDLE on clear with a cnt_clr pulse.
REQ-018 STOP SHALL go to RUN on start and to IDLE on clear with a cnt_clr pulse; lap SHALL be ignored.
REQ-019 Simultaneous press pulses SHALL resolve with priority clear > stop > start > lap, acting on one event only.
REQ-020 The state register SHALL update on the clock edge after the press pulse; cnt_clr and hold SHALL be registered and change on that same edge.
REQ-021 hold SHALL be 1 exactly while state==LAP.
REQ-022 The tick divider SHALL count 0..TICK_DIV-1 and wrap to 0, raising an internal tick at TICK_DIV-1.
REQ-023 The divider SHALL restart at 0 on the IDLE->RUN transition and on every cnt_clr, so the first cnt_en comes TICK_DIV cycles after start.
REQ-024 The divider SHALL keep running in STOP (phase kept, no strobe), so resume-to-first-strobe is at most TICK_DIV cycles.
REQ-025 cnt_en SHALL be a registered copy of (tick AND (state==RUN OR state==LAP)); it SHALL be one cycle wide and never asserted with cnt_clr.
REQ-026 Counting SHALL continue in LAP; only the display freezes.

Reset
REQ-027 RST SHALL force state=IDLE, cnt_en=0, cnt_clr=0, hold=0 and running=0, clear the divider and debounce counters, and set synchronizer and accepted levels to 0.
REQ-028 A button held through reset release SHALL produce one press pulse once DB_CYCLES stable samples are seen after release.
REQ-029 Reset asserted mid-RUN SHALL drop running and cnt_en on the same edge.

Configuration
REQ-030 Macro STOPWATCH_LAP_EN SHALL compile the lap feature in.
REQ-031 When STOPWATCH_LAP_EN is defined, REQ-016 to REQ-021 SHALL apply in full.
REQ-032 When STOPWATCH_LAP_EN is undefined, the BTNU port SHALL remain but be ignored, there SHALL be no LAP state and no BTNU debouncer, hold SHALL be tied 0, and state SHALL never equal 3.

Verification (DB_CYCLES=4, TICK_DIV=10)
REQ-033 Start: BTNL high for 10 cycles -> state=1 exactly 2+4+1 cycles after BTNL rises; first cnt_en 10 cycles later, then every 10 cycles.
REQ-034 Bounce: BTNL toggled every 2 cycles for 20 cycles, then held -> one transition only, after 4 stable samples.
REQ-035 Stop/resume: stop in RUN -> no cnt_en while state=2; start -> cnt_en resumes within 10 cycles, and the divider is not reset.
REQ-036 Clear: BTND in STOP -> one cnt_clr pulse, state=0, no cnt_en; BTND and BTNL in the same cycle -> clear wins.
REQ-037 Lap (macro on): BTNU in RUN -> state=3, hold=1, cnt_en continues every 10 cycles; BTNU again -> state=1, hold=0. With the macro off, BTNU has no effect.
REQ-038 Reset: RST during RUN -> next edge state=0 and all outputs 0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   Stopwatch control: debounces the four front-panel buttons, runs the
//   start/stop/clear/lap state machine and produces the increment and clear
//   strobes for an external BCD time counter.
//
//   Optional feature: define STOPWATCH_LAP_EN to build the lap function
//   (LAP state, BTNU debouncer, hold output). Without it BTNU is ignored,
//   hold is tied low and the state never reaches 3.
//
// Parameters
//   DB_CYCLES : consecutive equal samples needed to accept a button level
//   TICK_DIV  : CLK cycles per count tick
//
// Ports
//   CLK     in   system clock
//   RST     in   synchronous active-high reset
//   BTNL    in   raw start button (asynchronous)
//   BTNR    in   raw stop button (asynchronous)
//   BTND    in   raw clear button (asynchronous)
//   BTNU    in   raw lap button (asynchronous)
//   cnt_en  out  one-cycle increment strobe to the time counter
//   cnt_clr out  one-cycle clear strobe to the time counter
//   hold    out  freezes the display latch while in lap view
//   state   out  current FSM state (IDLE=0, RUN=1, STOP=2, LAP=3)
//   running out  high while counting (RUN or LAP)
// ---------------------------------------------------------------------------

// Per-button synchronizer + debouncer + rising-edge press detector.
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   raw   in   asynchronous button level
//   press out  one-cycle pulse when the accepted level goes 0->1
module stopwatch_debounce #(
    parameter int DB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync_p0;
    logic            sync_p1;
    logic            level;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            // stage p0 -> p1: two-flop synchronizer
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            // stage p1 -> level: cnt holds how many samples in a row have
            // disagreed with the accepted level; any agreeing sample
            // restarts the count, so bounce never accumulates.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt   <= '0;
                level <= sync_p1;
                press <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int DB_CYCLES = 100000,
    parameter int TICK_DIV  = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTNL,
    input  logic       BTNR,
    input  logic       BTND,
    input  logic       BTNU,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       hold,
    output logic [1:0] state,
    output logic       running
);
    localparam int TD_W = $clog2(TICK_DIV + 1);
    localparam logic [TD_W-1:0] TD_LAST = TD_W'(TICK_DIV - 1);

`ifdef STOPWATCH_LAP_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;
`endif

    state_t          state_q;
    state_t          state_next;
    logic            clr_evt;
    logic            restart;
    logic            tick;
    logic [TD_W-1:0] div;

    logic press_start;
    logic press_stop;
    logic press_clr;

    function automatic logic is_counting(input state_t s);
`ifdef STOPWATCH_LAP_EN
        return (s == RUN) || (s == LAP);
`else
        return (s == RUN);
`endif
    endfunction

    stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk(CLK), .rst(RST), .raw(BTNL), .press(press_start)
    );
    stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
        .clk(CLK), .rst(RST), .raw(BTNR), .press(press_stop)
    );
    stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk(CLK), .rst(RST), .raw(BTND), .press(press_clr)
    );

`ifdef STOPWATCH_LAP_EN
    logic press_lap;
    stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk(CLK), .rst(RST), .raw(BTNU), .press(press_lap)
    );
`else
    // Lap button is present on the board but has no function in this build.
    logic unused_btnu;
    assign unused_btnu = BTNU;
    assign hold        = 1'b0;
`endif

    // Exactly one press is acted on per cycle: the highest-priority pulse
    // present (clear > stop > start > lap) is taken, even if the current
    // state then ignores it.
    always_comb begin
        state_next = state_q;
        clr_evt    = 1'b0;
        if (press_clr) begin
            state_next = IDLE;
            clr_evt    = 1'b1;
        end else if (press_stop) begin
            if (is_counting(state_q)) state_next = STOP;
        end else if (press_start) begin
            if ((state_q == IDLE) || (state_q == STOP)) state_next = RUN;
`ifdef STOPWATCH_LAP_EN
        end else if (press_lap) begin
            case (state_q)
                RUN:     state_next = LAP;
                LAP:     state_next = RUN;
                default: state_next = state_q;
            endcase
`endif
        end
    end

    assign tick    = (div == TD_LAST);
    // Restarting on start-from-idle and on clear makes the first strobe
    // land a full tick period after start; resume from STOP keeps phase.
    assign restart = clr_evt || ((state_q == IDLE) && (state_next == RUN));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            div     <= '0;
`ifdef STOPWATCH_LAP_EN
            hold    <= 1'b0;
`endif
        end else begin
            state_q <= state_next;
            cnt_clr <= clr_evt;
            // Strobe only when counting both before and after this edge, so
            // a stop or clear taken on a tick cycle yields no stray strobe.
            cnt_en  <= tick && is_counting(state_q) && is_counting(state_next);
            if (restart || tick) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
`ifdef STOPWATCH_LAP_EN
            hold    <= (state_next == LAP);
`endif
        end
    end

    assign state   = state_q;
    assign running = is_counting(state_q);
endmodule
